exit_monitor: RTL and testbench
===============================

EXIT_MONITOR -- requirements
Module: exit_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent exit channels (one per hart), 1..32.
REQ-002 SHALL have parameter VALUE_W, default 32: width of each exit value.
REQ-003 SHALL have parameter CNT_W, default 32: width of the cycle counter and timeout limit.
REQ-004 SHALL have parameter RESET_WAIT_CYCLES, default 4: cycles the core reset is held after rst_ni deasserts, 1..255.
REQ-005 SHALL have parameter MODE_ALL, default 1: 1 means done when all channels exit; 0 means done when any channel exits.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port clear_i, input, 1 bit: synchronous restart of the whole sequence.
REQ-009 SHALL have port max_cycles_i, input, CNT_W bits: watchdog limit; 0 disables the watchdog.
REQ-010 SHALL have port exit_valid_i, input, NUM_CH bits: per-channel exit strobe.
REQ-011 SHALL have port exit_value_i, input, NUM_CH*VALUE_W bits: per-channel exit value, channel c at bits [c*VALUE_W +: VALUE_W].
REQ-012 SHALL have port core_rst_no, output, 1 bit: sequenced active-low reset to the DUT.
REQ-013 SHALL have port done_o, output, 1 bit: test finished (sticky).
REQ-014 SHALL have port pass_o, output, 1 bit: qualified by done_o.
REQ-015 SHALL have port timeout_o, output, 1 bit: watchdog expired.
REQ-016 SHALL have port exited_o, output, NUM_CH bits: channels that have exited.
REQ-017 SHALL have port fail_o, output, NUM_CH bits: channels that exited with a nonzero value.
REQ-018 SHALL have port first_fail_value_o, output, VALUE_W bits: value of the lowest-index failing channel.
REQ-019 SHALL have port cycle_count_o, output, CNT_W bits: cycles in RUN, frozen at done.

Function
REQ-020 SHALL implement the FSM states HOLD, RUN and DONE.
REQ-021 HOLD SHALL count from 0 and move to RUN on the cycle after the count reaches RESET_WAIT_CYCLES-1.
REQ-022 core_rst_no SHALL be registered: 0 in HOLD and 1 in RUN and DONE, rising exactly RESET_WAIT_CYCLES cycles after the first clock edge with rst_ni high.
REQ-023 In RUN, the cycle counter SHALL increment by 1 per cycle and saturate at all-ones (no wrap).
REQ-024 Per channel, the first cycle with exit_valid_i[c]=1 in RUN SHALL set exited_o[c] and capture the value; later strobes on that channel are ignored (first value wins).
REQ-025 fail_o[c] SHALL be set when exited_o[c] is set and the captured value is nonzero.
REQ-026 exit_valid_i SHALL be ignored in HOLD and DONE.
REQ-027 Done condition: MODE_ALL=1 requires all exited bits set (including bits set this cycle); MODE_ALL=0 requires any exited bit set.
REQ-028 The watchdog SHALL fire when max_cycles_i != 0 and the counter >= max_cycles_i in RUN.
REQ-029 If the watchdog fires, RUN SHALL go to DONE and set timeout_o.
REQ-030 When the exit done condition and the watchdog fire in the same cycle, the exit SHALL win and timeout_o stays 0.
REQ-031 Multiple channels strobing in the same cycle SHALL all be captured in that cycle.
REQ-032 On the RUN->DONE transition, done_o SHALL rise one cycle after the deciding strobe or watchdog, and cycle_count_o freezes.
REQ-033 pass_o SHALL equal done_o & ~timeout_o & ~|fail_o.
REQ-034 first_fail_value_o SHALL be the captured value of the lowest-index set fail_o bit, else 0.
REQ-035 DONE SHALL be terminal until clear_i or reset.
REQ-036 clear_i in any state SHALL, at the next edge, enter HOLD, zero all outputs and counters, and drive core_rst_no=0.
REQ-037 clear_i SHALL have priority over exit strobes and the watchdog in the same cycle.

Reset
REQ-038 While rst_ni=0 (asynchronous), the block SHALL be in HOLD with hold count 0, core_rst_no=0, and done_o, pass_o, timeout_o, exited_o, fail_o, first_fail_value_o and cycle_count_o all 0.
REQ-039 Reset asserted mid-RUN or in DONE SHALL discard all captured results.

Structure
REQ-040 Package exit_monitor_pkg SHALL hold the state enum (HOLD/RUN/DONE) and the reset-wait counter width constant (8).
REQ-041 One sub-module, exit_ch_capture, SHALL be instantiated per channel; it holds the sticky exited flag, captured value and fail flag, with clear and enable inputs.

Verification
REQ-042 NUM_CH=2, MODE_ALL=1: ch0 exits with 0 at RUN cycle 10 and ch1 with 0 at cycle 20 -> done_o rises next cycle, pass_o=1, cycle_count_o=21.
REQ-043 MODE_ALL=1: ch1 exits with 5 and ch0 with 0 in the same cycle -> fail_o=2'b10, first_fail_value_o=5, pass_o=0.
REQ-044 max_cycles_i=100, no exits -> done_o and timeout_o rise with cycle_count_o=100 and pass_o=0; max_cycles_i=0 -> no done after 10000 cycles.
REQ-045 Final exit strobe coincident with watchdog expiry -> timeout_o=0 and pass_o reflects the values.
REQ-046 MODE_ALL=0: ch0 strobes 3, then strobes 0 -> done after first strobe, captured 3, later strobe ignored.
REQ-047 rst_ni pulsed low mid-RUN and clear_i in DONE -> core_rst_no low for exactly 4 cycles, all results zero, sequence repeats.

Source files
------------

// File: rtl/exit_monitor_pkg.sv
// Shared types for the exit monitor: FSM state encoding and the
// width of the post-reset hold counter.
package exit_monitor_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/exit_ch_capture.sv
// One exit channel: sticky exited flag, first captured value and a
// fail flag that marks a nonzero exit value.
module exit_ch_capture #(
    parameter int VALUE_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic [VALUE_W-1:0] value_i,
    output logic               exited_o,
    output logic               fail_o,
    output logic [VALUE_W-1:0] value_o
);

    logic               exited_q, exited_d;
    logic               fail_q, fail_d;
    logic [VALUE_W-1:0] value_q, value_d;

    always_comb begin
        exited_d = exited_q;
        fail_d   = fail_q;
        value_d  = value_q;
        if (clr_i) begin
            exited_d = 1'b0;
            fail_d   = 1'b0;
            value_d  = '0;
        end else if (en_i && valid_i && !exited_q) begin
            // only the first strobe is kept
            exited_d = 1'b1;
            fail_d   = |value_i;
            value_d  = value_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exited_q <= 1'b0;
            fail_q   <= 1'b0;
            value_q  <= '0;
        end else begin
            exited_q <= exited_d;
            fail_q   <= fail_d;
            value_q  <= value_d;
        end
    end

    assign exited_o = exited_q;
    assign fail_o   = fail_q;
    assign value_o  = value_q;

endmodule

// File: rtl/exit_monitor.sv
// Test-harness exit monitor: sequences the core reset, collects per-hart
// exit codes, runs a watchdog and reports a sticky pass/fail verdict.
module exit_monitor
    import exit_monitor_pkg::*;
#(
    parameter int NUM_CH            = 2,
    parameter int VALUE_W           = 32,
    parameter int CNT_W             = 32,
    parameter int RESET_WAIT_CYCLES = 4,
    parameter int MODE_ALL          = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [CNT_W-1:0]          max_cycles_i,
    input  logic [NUM_CH-1:0]         exit_valid_i,
    input  logic [NUM_CH*VALUE_W-1:0] exit_value_i,
    output logic                      core_rst_no,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [NUM_CH-1:0]         exited_o,
    output logic [NUM_CH-1:0]         fail_o,
    output logic [VALUE_W-1:0]        first_fail_value_o,
    output logic [CNT_W-1:0]          cycle_count_o
);

    localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(RESET_WAIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic               run;
    logic               cap_en;
    logic [NUM_CH-1:0]  exited;
    logic [NUM_CH-1:0]  fail;
    logic [VALUE_W-1:0] cap_val [NUM_CH];
    logic [NUM_CH-1:0]  exited_now;
    logic               exit_done;
    logic [CNT_W-1:0]   cyc_inc;
    logic               wdog;

    assign run    = (state_q == RUN);
    assign cap_en = run && !clear_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        exit_ch_capture #(
            .VALUE_W (VALUE_W)
        ) u_cap (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (clear_i),
            .en_i     (cap_en),
            .valid_i  (exit_valid_i[c]),
            .value_i  (exit_value_i[c*VALUE_W +: VALUE_W]),
            .exited_o (exited[c]),
            .fail_o   (fail[c]),
            .value_o  (cap_val[c])
        );
    end

    // include channels exiting this very cycle in the done decision
    assign exited_now = exited | exit_valid_i;
    assign exit_done  = (MODE_ALL != 0) ? &exited_now : |exited_now;
    assign cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
    assign wdog       = (max_cycles_i != '0) && (cyc_inc >= max_cycles_i);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cyc_d      = cyc_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        if (clear_i) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            cyc_d      = '0;
            core_rst_d = 1'b0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = RUN;
                        hold_cnt_d = '0;
                        core_rst_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + WAIT_W'(1);
                    end
                end
                RUN: begin
                    cyc_d = cyc_inc;
                    if (exit_done) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (wdog) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    core_rst_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            cyc_q      <= '0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cyc_q      <= cyc_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        first_fail_value_o = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (fail[c]) begin
                first_fail_value_o = cap_val[c];
            end
        end
    end

    assign core_rst_no   = core_rst_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign exited_o      = exited;
    assign fail_o        = fail;
    assign cycle_count_o = cyc_q;
    assign pass_o        = done_q & ~timeout_q & ~|fail;

endmodule

// File: tb/tb_exit_monitor.sv
// Directed bench for exit_monitor: one all-exit instance and one
// any-exit instance driven by the same stimulus.
module tb_exit_monitor;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] max_cycles;
    logic [1:0]  valid;
    logic [63:0] value;

    logic        a_core, a_done, a_pass, a_to;
    logic [1:0]  a_exited, a_fail;
    logic [31:0] a_ffv, a_cyc;
    logic        b_core, b_done, b_pass, b_to;
    logic [1:0]  b_exited, b_fail;
    logic [31:0] b_ffv, b_cyc;

    int checks = 0;
    int errors = 0;

    exit_monitor #(
        .NUM_CH(2), .VALUE_W(32), .CNT_W(32),
        .RESET_WAIT_CYCLES(4), .MODE_ALL(1)
    ) dut_all (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .max_cycles_i       (max_cycles),
        .exit_valid_i       (valid),
        .exit_value_i       (value),
        .core_rst_no        (a_core),
        .done_o             (a_done),
        .pass_o             (a_pass),
        .timeout_o          (a_to),
        .exited_o           (a_exited),
        .fail_o             (a_fail),
        .first_fail_value_o (a_ffv),
        .cycle_count_o      (a_cyc)
    );

    exit_monitor #(
        .NUM_CH(2), .VALUE_W(32), .CNT_W(32),
        .RESET_WAIT_CYCLES(4), .MODE_ALL(0)
    ) dut_any (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .max_cycles_i       (max_cycles),
        .exit_valid_i       (valid),
        .exit_value_i       (value),
        .core_rst_no        (b_core),
        .done_o             (b_done),
        .pass_o             (b_pass),
        .timeout_o          (b_to),
        .exited_o           (b_exited),
        .fail_o             (b_fail),
        .first_fail_value_o (b_ffv),
        .cycle_count_o      (b_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // status vector: {done, pass, timeout, exited[1:0], fail[1:0]}
    function automatic logic [6:0] a_stat();
        return {a_done, a_pass, a_to, a_exited, a_fail};
    endfunction

    function automatic logic [6:0] b_stat();
        return {b_done, b_pass, b_to, b_exited, b_fail};
    endfunction

    task automatic expect_hold(input string nm);
        logic exp;
        checks++;
        if (a_core !== 1'b0) begin
            errors++;
            $display("FAIL %s core_rst start: got %b exp 0", nm, a_core);
        end
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            exp = (i == 4) ? 1'b1 : 1'b0;
            checks++;
            if (a_core !== exp) begin
                errors++;
                $display("FAIL %s core_rst edge %0d: got %b exp %b",
                         nm, i, a_core, exp);
            end
        end
    endtask

    task automatic restart();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        expect_hold("restart");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({a_core, a_stat(), a_ffv, a_cyc} !== '0) begin
            errors++;
            $display("FAIL reset_all: got %b %b %h %h exp zeros",
                     a_core, a_stat(), a_ffv, a_cyc);
        end
        checks++;
        if ({b_core, b_stat(), b_ffv, b_cyc} !== '0) begin
            errors++;
            $display("FAIL reset_any: got %b %b %h %h exp zeros",
                     b_core, b_stat(), b_ffv, b_cyc);
        end
        tick(2);
        rst_n = 1'b1;
        expect_hold("reset");
        checks++;
        if (a_cyc !== 32'd0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL run_start: got cyc=%0d done=%b exp 0 0",
                     a_cyc, a_done);
        end
    endtask

    task automatic test_all_pass();
        tick(10);
        checks++;
        if (a_cyc !== 32'd10) begin
            errors++;
            $display("FAIL cyc10: got %0d exp 10", a_cyc);
        end
        valid = 2'b01;
        value = 64'd0;
        tick(1);
        valid = 2'b00;
        tick(9);
        checks++;
        if (a_stat() !== 7'b000_01_00 || a_cyc !== 32'd20) begin
            errors++;
            $display("FAIL all_mid: got %b cyc=%0d exp 0000100 20",
                     a_stat(), a_cyc);
        end
        valid = 2'b10;
        tick(1);
        valid = 2'b00;
        checks++;
        if (a_stat() !== 7'b110_11_00 || a_cyc !== 32'd21) begin
            errors++;
            $display("FAIL all_done: got %b cyc=%0d exp 1101100 21",
                     a_stat(), a_cyc);
        end
        valid = 2'b11;
        value = {32'd9, 32'd9};
        tick(3);
        valid = 2'b00;
        checks++;
        if (a_stat() !== 7'b110_11_00 || a_cyc !== 32'd21 ||
            a_ffv !== 32'd0) begin
            errors++;
            $display("FAIL done_sticky: got %b cyc=%0d ffv=%0d exp 1101100 21 0",
                     a_stat(), a_cyc, a_ffv);
        end
    endtask

    task automatic test_clear_done();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++;
        if ({a_core, a_stat(), a_ffv, a_cyc} !== '0) begin
            errors++;
            $display("FAIL clear_done: got %b %b %h %h exp zeros",
                     a_core, a_stat(), a_ffv, a_cyc);
        end
        expect_hold("clear");
    endtask

    task automatic test_clear_priority();
        tick(2);
        clear = 1'b1;
        valid = 2'b11;
        value = {32'd4, 32'd4};
        tick(1);
        clear = 1'b0;
        valid = 2'b00;
        checks++;
        if (a_stat() !== 7'd0 || a_cyc !== 32'd0) begin
            errors++;
            $display("FAIL clear_prio: got %b cyc=%0d exp 0000000 0",
                     a_stat(), a_cyc);
        end
        expect_hold("clear_prio");
    endtask

    task automatic test_fail_value();
        restart();
        tick(3);
        valid = 2'b11;
        value = {32'd5, 32'd0};
        tick(1);
        valid = 2'b00;
        checks++;
        if (a_stat() !== 7'b100_11_10 || a_ffv !== 32'd5 ||
            a_cyc !== 32'd4) begin
            errors++;
            $display("FAIL fail_val: got %b ffv=%0d cyc=%0d exp 1001110 5 4",
                     a_stat(), a_ffv, a_cyc);
        end
    endtask

    task automatic test_timeout();
        max_cycles = 32'd100;
        restart();
        tick(99);
        checks++;
        if (a_done !== 1'b0 || a_cyc !== 32'd99) begin
            errors++;
            $display("FAIL wdog_pre: got done=%b cyc=%0d exp 0 99",
                     a_done, a_cyc);
        end
        tick(1);
        checks++;
        if (a_stat() !== 7'b101_00_00 || a_cyc !== 32'd100) begin
            errors++;
            $display("FAIL wdog: got %b cyc=%0d exp 1010000 100",
                     a_stat(), a_cyc);
        end
    endtask

    task automatic test_no_watchdog();
        max_cycles = 32'd0;
        restart();
        tick(10000);
        checks++;
        if (a_done !== 1'b0 || a_to !== 1'b0 || a_cyc !== 32'd10000) begin
            errors++;
            $display("FAIL no_wdog: got done=%b to=%b cyc=%0d exp 0 0 10000",
                     a_done, a_to, a_cyc);
        end
    endtask

    task automatic test_coincident();
        max_cycles = 32'd100;
        restart();
        tick(20);
        valid = 2'b01;
        value = 64'd0;
        tick(1);
        valid = 2'b00;
        tick(78);
        checks++;
        if (a_done !== 1'b0 || a_cyc !== 32'd99) begin
            errors++;
            $display("FAIL coinc_pre: got done=%b cyc=%0d exp 0 99",
                     a_done, a_cyc);
        end
        valid = 2'b10;
        tick(1);
        valid = 2'b00;
        checks++;
        if (a_stat() !== 7'b110_11_00 || a_cyc !== 32'd100) begin
            errors++;
            $display("FAIL coinc: got %b cyc=%0d exp 1101100 100",
                     a_stat(), a_cyc);
        end
        max_cycles = 32'd0;
    endtask

    task automatic test_any_mode();
        restart();
        tick(5);
        valid = 2'b01;
        value = {32'd0, 32'd3};
        tick(1);
        valid = 2'b00;
        checks++;
        if (b_stat() !== 7'b100_01_01 || b_ffv !== 32'd3 ||
            b_cyc !== 32'd6) begin
            errors++;
            $display("FAIL any_done: got %b ffv=%0d cyc=%0d exp 1000101 3 6",
                     b_stat(), b_ffv, b_cyc);
        end
        checks++;
        if (a_done !== 1'b0 || a_exited !== 2'b01) begin
            errors++;
            $display("FAIL all_wait: got done=%b exited=%b exp 0 01",
                     a_done, a_exited);
        end
        tick(2);
        valid = 2'b01;
        value = 64'd0;
        tick(1);
        valid = 2'b00;
        checks++;
        if (b_stat() !== 7'b100_01_01 || b_ffv !== 32'd3 ||
            b_cyc !== 32'd6) begin
            errors++;
            $display("FAIL any_first: got %b ffv=%0d cyc=%0d exp 1000101 3 6",
                     b_stat(), b_ffv, b_cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        restart();
        tick(5);
        valid = 2'b01;
        value = {32'd0, 32'd7};
        tick(1);
        valid = 2'b00;
        checks++;
        if (a_exited !== 2'b01 || a_ffv !== 32'd7) begin
            errors++;
            $display("FAIL mid_cap: got exited=%b ffv=%0d exp 01 7",
                     a_exited, a_ffv);
        end
        tick(3);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a_core, a_stat(), a_ffv, a_cyc} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %b %b %h %h exp zeros",
                     a_core, a_stat(), a_ffv, a_cyc);
        end
        #1;
        rst_n = 1'b1;
        expect_hold("mid_reset");
        checks++;
        if (a_stat() !== 7'd0 || a_cyc !== 32'd0) begin
            errors++;
            $display("FAIL mid_rerun: got %b cyc=%0d exp 0000000 0",
                     a_stat(), a_cyc);
        end
        tick(2);
        valid = 2'b11;
        value = 64'd0;
        tick(1);
        valid = 2'b00;
        checks++;
        if (a_stat() !== 7'b110_11_00 || a_cyc !== 32'd3) begin
            errors++;
            $display("FAIL mid_repeat: got %b cyc=%0d exp 1101100 3",
                     a_stat(), a_cyc);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        max_cycles = 32'd0;
        valid      = 2'b00;
        value      = 64'd0;
        test_reset();
        test_all_pass();
        test_clear_done();
        test_clear_priority();
        test_fail_value();
        test_timeout();
        test_no_watchdog();
        test_coincident();
        test_any_mode();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
